// File: rtl/mac_pipe.sv
// Two-stage pipelined unsigned multiply-add with valid/ready handshakes,
// frame-accumulate mode (dot product plus offset), optional saturation and overflow flag.
module mac_pipe #(
    parameter int SIZE_REG      = 8,
    parameter int SIZE_DATA_OUT = 24,
    parameter int LEN_W         = 8,
    parameter int SAT           = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIZE_REG-1:0]      A,
    input  logic [SIZE_REG-1:0]      B,
    input  logic [SIZE_REG-1:0]      C,
    input  logic                     mode,
    input  logic [LEN_W-1:0]         len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE_DATA_OUT-1:0] DATA_OUT,
    output logic                     overflow,
    output logic                     busy
);

    localparam int PW = 2 * SIZE_REG;
    localparam int SW = SIZE_DATA_OUT + 1;

    // Frame tracking on the accept side: cnt counts terms of the current frame already taken in.
    logic [LEN_W-1:0]         r_cnt;
    logic                     r_mode;
    logic [LEN_W-1:0]         r_len_eff;

    logic                     r_s1_valid;
    logic                     r_s1_first;
    logic                     r_s1_last;
    logic [PW-1:0]            r_p;
    logic [SIZE_REG-1:0]      r_c;

    logic [SIZE_DATA_OUT-1:0] r_acc;
    logic                     r_acc_ovf;
    logic                     r_out_valid;
    logic [SIZE_DATA_OUT-1:0] r_data_out;
    logic                     r_overflow;

    logic                     w_en;
    logic                     w_accept;
    logic                     w_first;
    logic                     w_mode;
    logic [LEN_W-1:0]         w_len_in;
    logic [LEN_W-1:0]         w_len_eff;
    logic                     w_last;
    logic [SIZE_DATA_OUT-1:0] w_base;
    logic [SW-1:0]            w_sum;
    logic                     w_ovf;
    logic [SIZE_DATA_OUT-1:0] w_val;

    assign w_en      = !r_out_valid || out_ready;
    assign w_accept  = in_valid && w_en;
    assign w_first   = (r_cnt == '0);
    assign w_len_in  = (len == '0) ? LEN_W'(1) : len;
    // mode/len presented mid-frame are ignored; the values latched with the first term rule.
    assign w_mode    = w_first ? mode : r_mode;
    assign w_len_eff = w_first ? w_len_in : r_len_eff;
    assign w_last    = !w_mode || (r_cnt == w_len_eff - LEN_W'(1));

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_base = r_acc;
        w_ovf  = 1'b0;
        if (r_s1_first) begin
            w_base = SIZE_DATA_OUT'(r_c);
        end
        w_sum = SW'(w_base) + SW'(r_p);
        w_ovf = (!r_s1_first && r_acc_ovf) || w_sum[SIZE_DATA_OUT];
        w_val = ((SAT != 0) && w_ovf) ? '1 : w_sum[SIZE_DATA_OUT-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_len_eff  <= LEN_W'(1);
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_p        <= '0;
            r_c        <= '0;
        end else if (w_en) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_p        <= A * B;
                r_c        <= C;
                r_s1_first <= w_first;
                r_s1_last  <= w_last;
                r_cnt      <= w_last ? '0 : r_cnt + LEN_W'(1);
                if (w_first) begin
                    r_mode    <= mode;
                    r_len_eff <= w_len_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_acc_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
        end else if (w_en) begin
            if (r_s1_valid && r_s1_last) begin
                r_out_valid <= 1'b1;
                r_data_out  <= w_val;
                r_overflow  <= w_ovf;
            end else begin
                r_out_valid <= 1'b0;
            end
            if (r_s1_valid && !r_s1_last) begin
                r_acc     <= w_val;
                r_acc_ovf <= w_ovf;
            end
        end
    end

    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign DATA_OUT  = r_data_out;
    assign overflow  = r_overflow;
    assign busy      = r_s1_valid || (r_cnt != '0);

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: default 24-bit instance plus 16-bit saturating and wrapping
// instances driven from the same stimulus.
module tb_mac_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a, b, c;
    logic        mode;
    logic [7:0]  len;

    logic        in_ready, out_valid, overflow, busy;
    logic [23:0] data_out;
    logic        s_in_ready, s_out_valid, s_overflow, s_busy;
    logic [15:0] s_data_out;
    logic        w_in_ready, w_out_valid, w_overflow, w_busy;
    logic [15:0] w_data_out;

    int n_vec = 0;
    int n_err = 0;

    mac_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .C(c), .mode(mode), .len(len),
        .out_valid(out_valid), .out_ready(out_ready), .DATA_OUT(data_out),
        .overflow(overflow), .busy(busy)
    );

    mac_pipe #(.SIZE_REG(8), .SIZE_DATA_OUT(16), .LEN_W(8), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .A(a), .B(b), .C(c), .mode(mode), .len(len),
        .out_valid(s_out_valid), .out_ready(out_ready), .DATA_OUT(s_data_out),
        .overflow(s_overflow), .busy(s_busy)
    );

    mac_pipe #(.SIZE_REG(8), .SIZE_DATA_OUT(16), .LEN_W(8), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .A(a), .B(b), .C(c), .mode(mode), .len(len),
        .out_valid(w_out_valid), .out_ready(out_ready), .DATA_OUT(w_data_out),
        .overflow(w_overflow), .busy(w_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_term(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tc,
                            input logic tm, input logic [7:0] tl);
        in_valid = 1'b1;
        a = ta; b = tb; c = tc; mode = tm; len = tl;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; mode = 1'b0; len = '0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (data_out !== 24'd0) begin n_err++; $display("FAIL rst_data: got %0d want 0", data_out); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        tick();
        rst_n = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_mode0();
        set_term(3, 4, 5, 0, 0);
        tick();
        idle();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL m0_busy: got %b want 1", busy); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL m0_early: got %b want 0", out_valid); end
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL m0_valid: got %b want 1", out_valid); end
        n_vec++; if (data_out !== 24'd17) begin n_err++; $display("FAIL m0_data: got %0d want 17", data_out); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL m0_ovf: got %b want 0", overflow); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL m0_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        set_term(1, 1, 0, 0, 0);
        tick();
        set_term(2, 2, 1, 0, 0);
        tick();
        idle();
        n_vec++; if (out_valid !== 1'b1 || data_out !== 24'd1) begin n_err++; $display("FAIL b2b_first: got v=%b d=%0d want v=1 d=1", out_valid, data_out); end
        tick();
        n_vec++; if (out_valid !== 1'b1 || data_out !== 24'd5) begin n_err++; $display("FAIL b2b_second: got v=%b d=%0d want v=1 d=5", out_valid, data_out); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_frame();
        set_term(2, 3, 10, 1, 3);
        tick();
        set_term(4, 5, 99, 1, 3);
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL frm_no_out1: got %b want 0", out_valid); end
        set_term(1, 1, 99, 1, 3);
        tick();
        idle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL frm_no_out2: got %b want 0", out_valid); end
        tick();
        n_vec++; if (out_valid !== 1'b1 || data_out !== 24'd37) begin n_err++; $display("FAIL frm_result: got v=%b d=%0d want v=1 d=37", out_valid, data_out); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL frm_single: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL frm_busy: got %b want 0", busy); end
    endtask

    task automatic test_saturation();
        set_term(255, 255, 0, 1, 2);
        tick();
        set_term(255, 255, 0, 1, 2);
        tick();
        idle();
        tick();
        n_vec++; if (s_out_valid !== 1'b1 || s_data_out !== 16'd65535) begin n_err++; $display("FAIL sat_data: got v=%b d=%0d want v=1 d=65535", s_out_valid, s_data_out); end
        n_vec++; if (s_overflow !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %b want 1", s_overflow); end
        n_vec++; if (w_out_valid !== 1'b1 || w_data_out !== 16'd64514) begin n_err++; $display("FAIL wrap_data: got v=%b d=%0d want v=1 d=64514", w_out_valid, w_data_out); end
        n_vec++; if (w_overflow !== 1'b1) begin n_err++; $display("FAIL wrap_ovf: got %b want 1", w_overflow); end
        n_vec++; if (data_out !== 24'd130050 || overflow !== 1'b0) begin n_err++; $display("FAIL wide_sum: got d=%0d o=%b want d=130050 o=0", data_out, overflow); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_term(10, 10, 0, 0, 0);
        tick();
        set_term(20, 20, 0, 0, 0);
        tick();
        set_term(30, 30, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            n_vec++; if (out_valid !== 1'b1 || data_out !== 24'd100) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d want v=1 d=100", i, out_valid, data_out); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        idle();
        n_vec++; if (out_valid !== 1'b1 || data_out !== 24'd400) begin n_err++; $display("FAIL bp_second: got v=%b d=%0d want v=1 d=400", out_valid, data_out); end
        tick();
        n_vec++; if (out_valid !== 1'b1 || data_out !== 24'd900) begin n_err++; $display("FAIL bp_third: got v=%b d=%0d want v=1 d=900", out_valid, data_out); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_frame();
        set_term(1, 1, 0, 1, 4);
        tick();
        set_term(2, 2, 0, 1, 4);
        tick();
        idle();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmf_busy_pre: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || data_out !== 24'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rmf_cleared: got v=%b d=%0d o=%b busy=%b want all 0", out_valid, data_out, overflow, busy);
        end
        tick();
        rst_n = 1'b1;
        set_term(2, 2, 1, 1, 1);
        tick();
        idle();
        tick();
        n_vec++; if (out_valid !== 1'b1 || data_out !== 24'd5) begin n_err++; $display("FAIL rmf_new_frame: got v=%b d=%0d want v=1 d=5", out_valid, data_out); end
        tick();
    endtask

    task automatic test_len_zero_and_change();
        set_term(3, 3, 1, 1, 0);
        tick();
        idle();
        tick();
        n_vec++; if (out_valid !== 1'b1 || data_out !== 24'd10) begin n_err++; $display("FAIL len0_data: got v=%b d=%0d want v=1 d=10", out_valid, data_out); end
        n_vec++; if (s_overflow !== 1'b0) begin n_err++; $display("FAIL len0_ovf_cleared: got %b want 0", s_overflow); end
        tick();
        set_term(1, 2, 3, 1, 2);
        tick();
        set_term(2, 2, 7, 0, 5);
        tick();
        idle();
        tick();
        n_vec++; if (out_valid !== 1'b1 || data_out !== 24'd9) begin n_err++; $display("FAIL chg_data: got v=%b d=%0d want v=1 d=9", out_valid, data_out); end
        tick();
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL chg_idle: got v=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_back_to_back();
        test_frame();
        test_saturation();
        test_backpressure();
        test_reset_mid_frame();
        test_len_zero_and_change();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
